// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: instruction width, the canonical NOP,
// and the packet that travels from fetch to decode.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch/decode queue: DEPTH packets, one synchronous write
// port and one asynchronous read port so the head is visible without a read cycle.
module fetch_queue_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_pkt_t    wdata,
    input  logic [AW-1:0] raddr,
    output fetch_pkt_t    rdata
);

    fetch_pkt_t mem_q [DEPTH];

    // Contents carry no reset: stale entries are never visible because the
    // occupancy counter gates every read at the top level.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we && (waddr == AW'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode with valid/ready on both sides and
// a redirect flush. Optional same-cycle forwarding when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_decode_queue #(
    parameter int                DEPTH     = 4,
    parameter int                XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]   NOP_INSTR = riscv_pkg::NOP_INSTR,
    localparam int               AW        = $clog2(DEPTH),
    localparam int               CW        = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  bypass_taken;
    logic                  queued_valid;
    riscv_pkg::fetch_pkt_t wr_pkt;
    riscv_pkg::fetch_pkt_t head_pkt;

    assign queued_valid = (count_q != '0);
    assign in_ready     = (count_q < DEPTH_C);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch packet straight to decode; if decode
    // takes it this cycle, it never touches storage.
    assign bypass       = !queued_valid && in_valid && !flush;
    assign bypass_taken = bypass && out_ready;
`else
    assign bypass       = 1'b0;
    assign bypass_taken = 1'b0;
`endif

    assign push = in_valid && in_ready && !flush && !bypass_taken;
    assign pop  = queued_valid && out_ready && !flush;

    assign wr_pkt = '{instr: in_instr, pc: in_pc, pc_plus4: in_pc_plus4};

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail_q),
        .wdata (wr_pkt),
        .raddr (head_q),
        .rdata (head_pkt)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        out_valid    = 1'b0;
        out_instr    = NOP_INSTR;
        out_pc       = '0;
        out_pc_plus4 = '0;
        if (queued_valid) begin
            out_valid    = 1'b1;
            out_instr    = head_pkt.instr;
            out_pc       = head_pkt.pc;
            out_pc_plus4 = head_pkt.pc_plus4;
        end else if (bypass) begin
            out_valid    = 1'b1;
            out_instr    = in_instr;
            out_pc       = in_pc;
            out_pc_plus4 = in_pc_plus4;
        end
    end

    assign count = count_q;

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch stage and decode.
- Buffers fetched instruction words together with their PC and PC+4, so I-cache/fetch timing is decoupled from decode stalls.
- Valid/ready handshake on both sides.
- Flush input discards all buffered instructions when a jump or branch redirects the PC.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- XLEN, 32, width of instruction, PC and PC+4 fields.
- NOP_INSTR, 32'h00000013, value driven on out_instr when no instruction is valid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  XLEN  instruction word from the I-cache.
- in_pc  in  XLEN  address of in_instr.
- in_pc_plus4  in  XLEN  in_pc + 4, as computed by fetch.
- flush  in  1  discard all queued and in-flight entries; driven by the redirect logic on a taken jump or branch.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts the entry.
- out_instr  out  XLEN  head instruction, or NOP_INSTR when out_valid=0.
- out_pc  out  XLEN  head PC, or 0 when out_valid=0.
- out_pc_plus4  out  XLEN  head PC+4, or 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {instr, pc, pc_plus4}.
- Pointers: head and tail, $clog2(DEPTH) bits each, wrap naturally modulo DEPTH.
- count is held in a separate register.
- Push: in_valid && in_ready && !flush. The entry is written at tail, then tail increments.
- Pop: out_valid && out_ready && !flush. head increments.
- in_ready = (count < DEPTH). It is independent of out_ready, so a full queue does not accept in the same cycle as a pop. This is combinationally clean by design.
- out_valid = (count != 0).
- Output fields are read combinationally from the head entry.
- Latency: an instruction pushed in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Flush has the highest priority. On the next edge: head=tail=0, count=0, out_valid=0. A push in the same cycle is dropped. A pop in the same cycle is not counted as a decode accept; decode must ignore out_* while flush=1.
- Reset (rst=0 at the edge) has priority over flush and push/pop. head=tail=count=0, and all outputs take their out_valid=0 values.
- Reset mid-operation discards all contents. Storage RAM contents are don't-care after reset.
- No pointer overflow is possible: a push is blocked at count=DEPTH and a pop is blocked at count=0.
- The queue has no state machine beyond the occupancy counter; the pointer/count logic is the sequential core.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count=0 and in_valid=1, the input is forwarded combinationally to the outputs:
  - out_valid=1, with out_* taken from in_*.
  - If out_ready=1 in that cycle, the entry is consumed and not written, so zero-cycle latency.
  - If out_ready=0, the entry is written normally.
  - A flush still suppresses the bypass, forcing out_valid=0.
- Not defined: minimum latency is 1 cycle, and outputs depend only on registered state.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN constant
  - NOP_INSTR constant
  - fetch_pkt_t typedef {instr, pc, pc_plus4}
- One sub-module: fetch_queue_mem, a DEPTH x fetch_pkt_t register array with one write port and an asynchronous read port.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 → count=0, out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1.
- Fill and drain:
  - Push 4 instrs (pc 0x0,0x4,0x8,0xC) with out_ready=0 → count=4, in_ready=0.
  - A 5th push is ignored.
  - Then out_ready=1 → outputs pc 0x0,0x4,0x8,0xC in order, count 3,2,1,0.
- Concurrent: with count=2, push and pop every cycle for 10 cycles → count stays 2, output PCs strictly sequential, pointers wrap past entry 3.
- Flush:
  - With count=3, assert flush together with in_valid=1 (pc 0x40) → next cycle count=0, out_valid=0.
  - pc 0x40 never appears on the outputs.
- Flush vs reset: rst=0 and flush=1 in the same cycle → reset state; next push of pc 0x100 appears at the output one cycle later.
- Bypass (FETCH_QUEUE_BYPASS_EN):
  - Empty queue, in_valid=1, out_ready=1, pc 0x200 → out_valid=1 and out_pc=0x200 in the same cycle, count stays 0.
  - Without the macro, out_valid=1 one cycle later, with count=1.
